// File: rtl/cordic_divide_ctrl.sv
// Iterative linear-vectoring CORDIC divider: one shared add/shift stage
// reused for ITER micro-rotations, returning z ~= y/x with PARA = 1.0.
module cordic_divide_ctrl #(
  parameter int          ITER = 16,
  parameter logic [16:0] PARA = 17'h08000
) (
  input  logic        rx_clk,
  input  logic        rx_rst,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [31:0] rx_x,
  input  logic [31:0] rx_y,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [16:0] tx_z,
  output logic [31:0] tx_res,
  output logic [1:0]  tx_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0]  LAST_I    = 5'(ITER - 1);
  localparam logic [16:0] Z_POS_SAT = 17'h0FFFF;
  localparam logic [16:0] Z_NEG_SAT = 17'h10001;

  state_t      state_r, state_s;
  logic [4:0]  i_r, i_s;
  logic [31:0] x_r, x_s;
  logic [31:0] y_r, y_s;
  logic [16:0] z_r, z_s;
  logic [16:0] tx_z_s;
  logic [31:0] tx_res_s;
  logic [1:0]  tx_err_s;
  logic        tx_valid_s;

  logic [31:0] abs_x_s, abs_y_s;
  logic        range_err_s;
  logic [31:0] x_step_s, y_upd_s;
  logic [16:0] z_step_s, z_upd_s;

  // Magnitude as 32-bit unsigned; -2^31 maps to 2^31, which still fits.
  function automatic logic [31:0] magnitude(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

  assign abs_x_s     = magnitude(rx_x);
  assign abs_y_s     = magnitude(rx_y);
  assign range_err_s = {1'b0, abs_y_s} >= {abs_x_s, 1'b0};

  assign x_step_s = $signed(x_r) >>> i_r;
  assign z_step_s = $signed(PARA) >>> i_r;
  assign y_upd_s  = y_r[31] ? (y_r + x_step_s) : (y_r - x_step_s);
  assign z_upd_s  = y_r[31] ? (z_r - z_step_s) : (z_r + z_step_s);

  assign rx_ready = (state_r == IDLE) && !rx_rst;

  // Next-state and next-datapath decode for the sequencer.
  always_comb begin
    state_s    = state_r;
    i_s        = i_r;
    x_s        = x_r;
    y_s        = y_r;
    z_s        = z_r;
    tx_z_s     = tx_z;
    tx_res_s   = tx_res;
    tx_err_s   = tx_err;
    tx_valid_s = tx_valid;
    case (state_r)
      IDLE: begin
        if (rx_valid) begin
          if (rx_x == 32'd0) begin
            tx_err_s   = 2'b01;
            tx_z_s     = rx_y[31] ? Z_NEG_SAT : Z_POS_SAT;
            tx_res_s   = 32'd0;
            tx_valid_s = 1'b1;
            state_s    = DONE;
          end else if (range_err_s) begin
            tx_err_s   = 2'b10;
            tx_z_s     = (rx_y[31] ^ rx_x[31]) ? Z_NEG_SAT : Z_POS_SAT;
            tx_res_s   = 32'd0;
            tx_valid_s = 1'b1;
            state_s    = DONE;
          end else begin
            // Fold the divisor sign into the dividend so the loop sees x > 0.
            x_s      = rx_x[31] ? (32'd0 - rx_x) : rx_x;
            y_s      = rx_x[31] ? (32'd0 - rx_y) : rx_y;
            z_s      = 17'd0;
            i_s      = 5'd0;
            tx_err_s = 2'b00;
            state_s  = RUN;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        y_s = y_upd_s;
        z_s = z_upd_s;
        i_s = i_r + 5'd1;
        if (i_r == LAST_I) begin
          tx_z_s     = z_upd_s;
          tx_res_s   = y_upd_s;
          tx_valid_s = 1'b1;
          state_s    = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (tx_ready) begin
          tx_valid_s = 1'b0;
          state_s    = IDLE;
        end else begin
          tx_valid_s = 1'b1;
          state_s    = DONE;
        end
      end
      default: begin
        tx_valid_s = 1'b0;
        state_s    = IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      state_r  <= IDLE;
      i_r      <= 5'd0;
      x_r      <= 32'd0;
      y_r      <= 32'd0;
      z_r      <= 17'd0;
      tx_z     <= 17'd0;
      tx_res   <= 32'd0;
      tx_err   <= 2'b00;
      tx_valid <= 1'b0;
    end else begin
      state_r  <= state_s;
      i_r      <= i_s;
      x_r      <= x_s;
      y_r      <= y_s;
      z_r      <= z_s;
      tx_z     <= tx_z_s;
      tx_res   <= tx_res_s;
      tx_err   <= tx_err_s;
      tx_valid <= tx_valid_s;
    end
  end

endmodule
